// File: rtl/ps2_keyboard_rx_if.sv
// ps2_keyboard_rx_if: PS/2 line inputs and decoded key outputs bundle.
// The err_count signal exists only when PS2_ERR_COUNT_EN is defined.
interface ps2_keyboard_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] scan_code;
  logic       key_valid;
  logic       key_held;
  logic       frame_error;
`ifdef PS2_ERR_COUNT_EN
  logic [7:0] err_count;
  modport master (output ps2_clk, ps2_data, input scan_code, key_valid, key_held, frame_error, err_count);
  modport slave  (input ps2_clk, ps2_data, output scan_code, key_valid, key_held, frame_error, err_count);
`else
  modport master (output ps2_clk, ps2_data, input scan_code, key_valid, key_held, frame_error);
  modport slave  (input ps2_clk, ps2_data, output scan_code, key_valid, key_held, frame_error);
`endif
endinterface

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 keyboard receiver tracking the held key's make code.
// Define PS2_ERR_COUNT_EN to add the saturating err_count output.
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic              clk,
  input logic              reset,
  ps2_keyboard_rx_if.slave bus
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;
  state_t        state_q, state_d;
  logic [1:0]    clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [9:0]    sh_q, sh_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          brk_q, brk_d, ext_q, ext_d;
  logic [7:0]    scan_q, scan_d;
  logic          held_q, held_d, kv_q, kv_d, fe_q, fe_d;
  logic          strobe, bit_in, frame_ok;
  logic [7:0]    rx_byte;
`ifdef PS2_ERR_COUNT_EN
  logic [7:0]    err_q, err_d;
  assign bus.err_count = err_q;
`endif
  assign bus.scan_code   = scan_q;
  assign bus.key_held    = held_q;
  assign bus.key_valid   = kv_q;
  assign bus.frame_error = fe_q;
  always_comb begin
    clk_sync_d = {clk_sync_q[0], bus.ps2_clk};
    dat_sync_d = {dat_sync_q[0], bus.ps2_data};
    filt_d     = filt_q;
    fcnt_d     = '0;
    // filtered level flips on the FILTER_LEN-th consecutive differing sample
    if (clk_sync_q[1] != filt_q) begin
      fcnt_d = (fcnt_q == FW'(FILTER_LEN - 1)) ? '0 : fcnt_q + 1'b1;
      filt_d = (fcnt_q == FW'(FILTER_LEN - 1)) ? clk_sync_q[1] : filt_q;
    end
    strobe   = filt_q & ~filt_d;
    bit_in   = dat_sync_q[1];
    rx_byte  = sh_q[7:0];
    frame_ok = sh_q[9] & (^sh_q[8:0]);
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    sh_d     = sh_q;
    tmo_d    = '0;
    brk_d    = brk_q;
    ext_d    = ext_q;
    scan_d   = scan_q;
    held_d   = held_q;
    kv_d     = 1'b0;
    fe_d     = 1'b0;
`ifdef PS2_ERR_COUNT_EN
    err_d    = err_q;
`endif
    case (state_q)
      IDLE: begin
        state_d  = (strobe && !bit_in) ? RECV : IDLE;
        bitcnt_d = (strobe && !bit_in) ? 4'd1 : 4'd0;
      end
      RECV: begin
        if (strobe) begin
          sh_d     = {bit_in, sh_q[9:1]};
          bitcnt_d = (bitcnt_q == 4'd10) ? 4'd0 : bitcnt_q + 4'd1;
          state_d  = (bitcnt_q == 4'd10) ? CHECK : RECV;
        end else if (filt_q && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d  = IDLE;
          bitcnt_d = 4'd0;
        end else begin
          tmo_d = filt_q ? tmo_q + 1'b1 : tmo_q;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (!frame_ok) begin
          fe_d = 1'b1;
`ifdef PS2_ERR_COUNT_EN
          err_d = err_q + {7'd0, err_q != 8'hFF};
`endif
        end else if (rx_byte == 8'hE0) begin
          ext_d = 1'b1;
        end else if (rx_byte == 8'hF0) begin
          brk_d = 1'b1;
        end else begin
          // break releases only the key currently held; prefixes are consumed here
          brk_d  = 1'b0;
          ext_d  = 1'b0;
          kv_d   = !brk_q && (rx_byte != scan_q);
          scan_d = brk_q ? ((rx_byte == scan_q) ? 8'h00 : scan_q) : rx_byte;
          held_d = brk_q ? ((rx_byte == scan_q) ? 1'b0 : held_q) : 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
      bitcnt_q   <= 4'd0;
      sh_q       <= '0;
      tmo_q      <= '0;
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
      scan_q     <= 8'h00;
      held_q     <= 1'b0;
      kv_q       <= 1'b0;
      fe_q       <= 1'b0;
`ifdef PS2_ERR_COUNT_EN
      err_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      bitcnt_q   <= bitcnt_d;
      sh_q       <= sh_d;
      tmo_q      <= tmo_d;
      brk_q      <= brk_d;
      ext_q      <= ext_d;
      scan_q     <= scan_d;
      held_q     <= held_d;
      kv_q       <= kv_d;
      fe_q       <= fe_d;
`ifdef PS2_ERR_COUNT_EN
      err_q      <= err_d;
`endif
    end
  end
endmodule
